// File: rtl/modn_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : modn_counter_pkg
// Brief    : Shared constants, width helper and direction type for modn_counter.
//            Optional up/down counting is enabled by MODN_COUNTER_UPDOWN_EN.
// Revision : 1.0 - initial release
// ============================================================================
package modn_counter_pkg;

    localparam int MODN_MAX = 65536;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } modn_dir_e;

    function automatic int modn_width(input int m);
        return $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/modn_counter_next.sv
`default_nettype none
// ============================================================================
// Module   : modn_counter_next
// Brief    : Combinational next-count, wrap and terminal flags for modn_counter.
//            Down-count path exists only with MODN_COUNTER_UPDOWN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module modn_counter_next
    import modn_counter_pkg::*;
#(
    parameter  int MODULUS = 6,
    localparam int W       = modn_width(MODULUS)
) (
    input  logic [W-1:0] q,
`ifdef MODN_COUNTER_UPDOWN_EN
    input  modn_dir_e    dir,
`endif
    output logic [W-1:0] q_next,
    output logic         wrap_flag,
    output logic         term_flag
);

    localparam logic [W:0] c_mod = (W+1)'(MODULUS);

    logic [W:0] w_q_ext;
    logic [W:0] w_inc;
    logic       w_term_up;

    // W+1-bit arithmetic: incrementing MODULUS-1 lands exactly on MODULUS,
    // so power-of-two moduli need no special handling.
    assign w_q_ext   = {1'b0, q};
    assign w_inc     = w_q_ext + (W+1)'(1);
    assign w_term_up = (w_inc == c_mod);

`ifdef MODN_COUNTER_UPDOWN_EN
    localparam logic [W-1:0] c_last = W'(MODULUS - 1);

    logic [W:0] w_dec;

    // The borrow bit of the decrement flags q == 0.
    assign w_dec = w_q_ext - (W+1)'(1);

    always_comb begin
        q_next    = '0;
        term_flag = 1'b0;
        if (dir == DIR_UP) begin
            term_flag = w_term_up;
            q_next    = w_term_up ? '0 : w_inc[W-1:0];
        end else begin
            term_flag = w_dec[W];
            q_next    = w_dec[W] ? c_last : w_dec[W-1:0];
        end
        wrap_flag = term_flag;
    end
`else
    assign term_flag = w_term_up;
    assign wrap_flag = w_term_up;
    assign q_next    = w_term_up ? '0 : w_inc[W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/modn_counter.sv
`default_nettype none
// ============================================================================
// Module   : modn_counter
// Brief    : Parametrised synchronous modulo-N counter with enable, clear, load,
//            cascade tc, one-shot mode; up/down with MODN_COUNTER_UPDOWN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module modn_counter
    import modn_counter_pkg::*;
#(
    parameter  int MODULUS = 6,
    parameter  int ONESHOT = 0,
    localparam int W       = modn_width(MODULUS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
`ifdef MODN_COUNTER_UPDOWN_EN
    input  logic         up_dn,
`endif
    output logic [W-1:0] q,
    output logic         tc,
    output logic         wrap,
    output logic         done,
    output logic         err
);

    localparam bit         c_oneshot = (ONESHOT != 0);
    localparam logic [W:0] c_mod     = (W+1)'(MODULUS);

    generate
        if (MODULUS < 2 || MODULUS > MODN_MAX) begin : g_bad_modulus
            $fatal(1, "modn_counter: MODULUS %0d outside 2..%0d", MODULUS, MODN_MAX);
        end
    endgenerate

    logic [W-1:0] r_q;
    logic         r_wrap;
    logic         r_done;
    logic         r_err;

    logic [W-1:0] w_q_next;
    logic         w_wrap;
    logic         w_term;
    logic         w_din_ok;

`ifdef MODN_COUNTER_UPDOWN_EN
    modn_dir_e w_dir;
    assign w_dir = up_dn ? DIR_UP : DIR_DOWN;
`endif

    modn_counter_next #(
        .MODULUS (MODULUS)
    ) u_next (
        .q         (r_q),
`ifdef MODN_COUNTER_UPDOWN_EN
        .dir       (w_dir),
`endif
        .q_next    (w_q_next),
        .wrap_flag (w_wrap),
        .term_flag (w_term)
    );

    assign w_din_ok = ({1'b0, din} < c_mod);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
            if (clr) begin
                r_q    <= '0;
                r_done <= 1'b0;
            end else if (load) begin
                r_done <= 1'b0;
                if (w_din_ok) begin
                    r_q <= din;
                end else begin
                    r_q   <= '0;
                    r_err <= 1'b1;
                end
            end else if (en && !r_done) begin
                // One-shot: the would-be wrap edge latches done and freezes q.
                if (c_oneshot && w_term) begin
                    r_done <= 1'b1;
                end else begin
                    r_q    <= w_q_next;
                    r_wrap <= w_wrap;
                end
            end
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign err  = r_err;
    assign done = c_oneshot ? r_done : 1'b0;
    assign tc   = en && w_term && !(c_oneshot && r_done);

endmodule
`default_nettype wire

// File: tb/tb_modn_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_modn_counter
// Brief    : Self-checking bench for modn_counter: MOD-6, one-shot MOD-10 and
//            a two-stage MOD-10 chain; up/down vectors with MODN_COUNTER_UPDOWN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modn_counter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_en, a_clr, a_load, a_dir;
    logic [2:0] a_din, a_q;
    logic       a_tc, a_wrap, a_done, a_err;

    logic       b_en, b_clr, b_load, b_dir;
    logic [3:0] b_din, b_q;
    logic       b_tc, b_wrap, b_done, b_err;

    logic       c_en, c_zero, c_dir;
    logic [3:0] c_din, c0_q, c1_q;
    logic       c0_tc, c0_wrap, c0_done, c0_err;
    logic       c1_tc, c1_wrap, c1_done, c1_err;

    int errors = 0;
    int checks = 0;

    modn_counter #(.MODULUS(6)) u_a (
        .clk(clk), .reset(reset), .en(a_en), .clr(a_clr), .load(a_load), .din(a_din),
`ifdef MODN_COUNTER_UPDOWN_EN
        .up_dn(a_dir),
`endif
        .q(a_q), .tc(a_tc), .wrap(a_wrap), .done(a_done), .err(a_err));

    modn_counter #(.MODULUS(10), .ONESHOT(1)) u_b (
        .clk(clk), .reset(reset), .en(b_en), .clr(b_clr), .load(b_load), .din(b_din),
`ifdef MODN_COUNTER_UPDOWN_EN
        .up_dn(b_dir),
`endif
        .q(b_q), .tc(b_tc), .wrap(b_wrap), .done(b_done), .err(b_err));

    modn_counter #(.MODULUS(10)) u_c0 (
        .clk(clk), .reset(reset), .en(c_en), .clr(c_zero), .load(c_zero), .din(c_din),
`ifdef MODN_COUNTER_UPDOWN_EN
        .up_dn(c_dir),
`endif
        .q(c0_q), .tc(c0_tc), .wrap(c0_wrap), .done(c0_done), .err(c0_err));

    modn_counter #(.MODULUS(10)) u_c1 (
        .clk(clk), .reset(reset), .en(c0_tc), .clr(c_zero), .load(c_zero), .din(c_din),
`ifdef MODN_COUNTER_UPDOWN_EN
        .up_dn(c_dir),
`endif
        .q(c1_q), .tc(c1_tc), .wrap(c1_wrap), .done(c1_done), .err(c1_err));

    typedef struct {
        logic       en, clr, load;
        logic [2:0] din;
        logic       tc;
        logic [2:0] q;
        logic       wrap, err;
    } vec_t;

    typedef struct {
        int    dut;
        int    q;
        logic  wrap, err, done;
        string tag;
    } exp_t;

    vec_t a_tbl[$];
    exp_t sb[$];

    function automatic vec_t v(input logic en, clr, load, input logic [2:0] din,
                               input logic tc, input logic [2:0] q, input logic wrap, err);
        vec_t r;
        r.en = en; r.clr = clr; r.load = load; r.din = din;
        r.tc = tc; r.q = q; r.wrap = wrap; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got 0 entries, expected 1");
            return;
        end
        e = sb.pop_front();
        case (e.dut)
            0: begin
                check({e.tag, " q"},    32'(a_q),    32'(e.q));
                check({e.tag, " wrap"}, 32'(a_wrap), 32'(e.wrap));
                check({e.tag, " err"},  32'(a_err),  32'(e.err));
                check({e.tag, " done"}, 32'(a_done), 32'(e.done));
            end
            1: begin
                check({e.tag, " q"},    32'(b_q),    32'(e.q));
                check({e.tag, " wrap"}, 32'(b_wrap), 32'(e.wrap));
                check({e.tag, " err"},  32'(b_err),  32'(e.err));
                check({e.tag, " done"}, 32'(b_done), 32'(e.done));
            end
            default: check({e.tag, " value"}, 32'(c1_q) * 32'd10 + 32'(c0_q), 32'(e.q));
        endcase
    endtask

    task automatic a_step(input vec_t t, input string tag);
        exp_t e;
        @(negedge clk);
        a_en = t.en; a_clr = t.clr; a_load = t.load; a_din = t.din;
        #1 check({tag, " tc"}, 32'(a_tc), 32'(t.tc));
        e.dut = 0; e.q = int'(t.q); e.wrap = t.wrap; e.err = t.err; e.done = 1'b0; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1 sb_pop();
    endtask

    task automatic b_step(input logic en, clr, load, input int din,
                          input logic tc, input int q, input logic done, err, input string tag);
        exp_t e;
        @(negedge clk);
        b_en = en; b_clr = clr; b_load = load; b_din = 4'(din);
        #1 check({tag, " tc"}, 32'(b_tc), 32'(tc));
        e.dut = 1; e.q = q; e.wrap = 1'b0; e.err = err; e.done = done; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1 sb_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   cnt;

        // Vector table for the MOD-6 counter, starting from q=0 after reset.
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd1,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd2,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd3,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd4,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd5,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, H,3'd0,H,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd1,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd2,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd3,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd4,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd5,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, H,3'd0,H,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd1,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd2,L,L));
        a_tbl.push_back(v(L,L,L,3'd0, L,3'd2,L,L));
        a_tbl.push_back(v(L,L,H,3'd3, L,3'd3,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd4,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd5,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, H,3'd0,H,L));
        a_tbl.push_back(v(L,L,H,3'd7, L,3'd0,L,H));
        a_tbl.push_back(v(L,L,L,3'd0, L,3'd0,L,L));
        a_tbl.push_back(v(L,L,H,3'd5, L,3'd5,L,L));
        a_tbl.push_back(v(L,L,L,3'd0, L,3'd5,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, H,3'd0,H,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd1,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd2,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd3,L,L));
        a_tbl.push_back(v(H,L,L,3'd0, L,3'd4,L,L));
        a_tbl.push_back(v(H,H,H,3'd2, L,3'd0,L,L));
        a_tbl.push_back(v(H,L,H,3'd5, L,3'd5,L,L));
        a_tbl.push_back(v(H,H,L,3'd0, H,3'd0,L,L));
        a_tbl.push_back(v(L,L,H,3'd6, L,3'd0,L,H));
        a_tbl.push_back(v(L,L,H,3'd0, L,3'd0,L,L));

        reset = 1'b1;
        a_en = 0; a_clr = 0; a_load = 0; a_din = '0; a_dir = 1'b1;
        b_en = 0; b_clr = 0; b_load = 0; b_din = '0; b_dir = 1'b1;
        c_en = 0; c_zero = 0; c_din = '0; c_dir = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset a q",    32'(a_q),    0);
        check("reset a tc",   32'(a_tc),   0);
        check("reset a wrap", 32'(a_wrap), 0);
        check("reset a err",  32'(a_err),  0);
        check("reset b q",    32'(b_q),    0);
        check("reset b done", 32'(b_done), 0);
        check("reset chain",  32'(c1_q) * 32'd10 + 32'(c0_q), 0);
        reset = 1'b0;

        foreach (a_tbl[i]) a_step(a_tbl[i], $sformatf("A[%0d]", i));

        for (int i = 1; i <= 9; i++) b_step(H,L,L,0, L,i,L,L, $sformatf("B count %0d", i));
        b_step(H,L,L,0,  H,9,H,L, "B done set");
        b_step(H,L,L,0,  L,9,H,L, "B tc masked");
        b_step(L,H,L,0,  L,0,L,L, "B clr");
        b_step(H,L,L,0,  L,1,L,L, "B restart");
        b_step(L,L,H,9,  L,9,L,L, "B load 9");
        b_step(H,L,L,0,  H,9,H,L, "B done after load");
        b_step(H,L,H,4,  L,4,L,L, "B load clears done");
        b_step(L,L,H,12, L,0,L,H, "B illegal load");
        b_step(H,L,L,0,  L,1,L,L, "B err one pulse");
        @(negedge clk);
        b_en = 1'b0; b_load = 1'b0;

        // Two-digit decimal chain: stage 1 advances on the edge stage 0 wraps.
        c_en = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 120; i++) begin
            cnt   = (cnt + 1) % 100;
            e.dut = 2; e.q = cnt; e.wrap = 1'b0; e.err = 1'b0; e.done = 1'b0;
            e.tag = $sformatf("chain %0d", i);
            sb.push_back(e);
            @(posedge clk);
            #1 sb_pop();
        end
        @(negedge clk);
        c_en = 1'b0;

`ifdef MODN_COUNTER_UPDOWN_EN
        a_step(v(L,L,H,3'd1, L,3'd1,L,L), "UD load 1");
        a_dir = 1'b0;
        a_step(v(H,L,L,3'd0, L,3'd0,L,L), "UD 1->0");
        a_step(v(H,L,L,3'd0, H,3'd5,H,L), "UD 0->5");
        a_step(v(H,L,L,3'd0, L,3'd4,L,L), "UD 5->4");
        a_dir = 1'b1;
`endif

        a_step(v(L,L,H,3'd2, L,3'd2,L,L), "R load 2");
        a_step(v(H,L,L,3'd0, L,3'd3,L,L), "R count");
        @(negedge clk);
        a_en = 1'b1; a_load = 1'b0; a_clr = 1'b0;
        #2 reset = 1'b1;
        #1 check("async reset q", 32'(a_q), 0);
        #1 reset = 1'b0;
        check("post reset hold", 32'(a_q), 0);
        @(posedge clk);
        #1 check("first count after reset", 32'(a_q), 1);
        a_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
